bounce_sprite_engine: RTL and testbench
=======================================

// Module: bounce_sprite_engine
// PURPOSE
//  Parametrised N-ball bounce engine: holds position/velocity for NUM_BALLS square sprites, advances all
//  of them once per frame (on vsync rising edge) and bounces them synchronously off the screen edges.
//  Sits between game logic and the LCD scanout driver; per-pixel hit/ID output, 1-cycle registered.
// PARAMETERS
//  NUM_BALLS   4    number of sprites (1..16)
//  H_RES       160  visible columns; legal X = 0..H_RES-BALL_SIZE
//  V_RES       128  visible rows;    legal Y = 0..V_RES-BALL_SIZE
//  BALL_SIZE   4    sprite edge length in pixels (power of 2 not required)
//  POS_W       9    signed position register width
//  VEL_W       4    signed velocity width (range -8..+7)
//  X0, Y0      60   initial position of ball 0; ball i starts at (X0+8*i, Y0+4*i) mod legal range
// PORTS
//  clk         in   1            system clock, also scanout pixel clock
//  reset       in   1            asynchronous, active-high
//  vsync       in   1            frame strobe from scanout driver, clk-synchronous level
//  hpos        in   8            current scan column
//  vpos        in   8            current scan row
//  run         in   1            1 = advance balls on each frame; 0 = freeze positions
//  pix_hit     out  1            scan pixel (hpos,vpos) lies inside some ball (registered)
//  pix_id      out  $clog2(N)    index of lowest-numbered ball covering the pixel; 0 when !pix_hit
//  busy        out  1            update sweep in progress
//  overrun     out  1            sticky: vsync edge arrived while busy; cleared only by reset
//  frame_cnt   out  8            frames processed, wraps 255->0
// BEHAVIOUR
//  - Reset: all outputs 0; FSM IDLE; ball i pos=(X0+8i, Y0+4i) clamped, vel=(i odd ? +2:-2, +2).
//  - vsync edge: vs_q registered; edge = vsync & ~vs_q. Only rising edge triggers; level ignored.
//  - FSM IDLE -> SWEEP on edge when run=1 (edge with run=0: frame_cnt still increments, no sweep).
//  - SWEEP: one ball per clk, idx 0..N-1; nx=x+vx, ny=y+vy (sign-extend vel to POS_W).
//      nx<0            -> x=-nx,              vx=-vx
//      nx>H_RES-BALL_SIZE -> x=2*(H_RES-BALL_SIZE)-nx, vx=-vx  (reflect, never leaves legal range)
//      else x=nx; same rules for Y with V_RES. Both axes may bounce in the same cycle (corner).
//  - SWEEP -> DONE after idx N-1; DONE (1 clk): frame_cnt++, busy drops -> IDLE. busy high N+1 clks.
//  - vsync edge during SWEEP/DONE: ignored for motion, overrun set to 1.
//  - Velocity of -8 negates to +7 saturated (no wrap to -8).
//  - Pixel path: for each ball, dh=hpos-x, dv=vpos-y as unsigned POS_W; inside = dh<BALL_SIZE && dv<BALL_SIZE.
//    Priority encode lowest index; register pix_hit/pix_id -> latency 1 clk from hpos/vpos.
//  - Positions read by pixel path may change mid-sweep; allowed (vsync period is blank).
//  - Async reset mid-sweep: returns to IDLE, restores initial state, no partial frame.
// CONFIGURATION
//  BSE_BALL_COLLIDE_EN defined: additional sticky-free output ball_collide (1 bit, registered) pulses
//    for the pixel cycle where >=2 balls cover the same scan pixel; during SWEEP, if ball idx overlaps
//    ball idx-1 after update (|dx|<BALL_SIZE && |dy|<BALL_SIZE), both vx of idx and idx-1 are negated.
//  Not defined: port absent, balls pass through each other, no extra logic.
// STRUCTURE
//  Package bse_pkg: FSM state enum {IDLE,SWEEP,DONE}, ball_t struct {x,y,vx,vy}, reflect() function.
//  Sub-module bse_axis_step: one-axis pos+vel step with reflect/negate, instanced for X and Y.
//  Ball state in NUM_BALLS-entry register array (not RAM: pixel path reads all entries in parallel).
// TESTING
//  1. Reset, N=4: ball0 (60,60) v(-2,+2), ball3 (84,72) v(+2,+2); all outputs 0 after reset release.
//  2. One vsync pulse, run=1: busy high 5 clks; ball0 -> (58,62); frame_cnt=1.
//  3. Ball0 forced x=1,vx=-2, vsync -> x=1, vx=+2; x=155,vx=+2 (H_RES=160,SIZE=4) -> x=155, vx=-2.
//  4. hpos=58,vpos=62 after step 2 -> pix_hit=1,pix_id=0 next clk; hpos=62 -> pix_hit=0, pix_id=0.
//  5. Second vsync edge 2 clks after first -> overrun=1, positions advance once only; run=0 freezes pos.
//  6. Assert reset mid-SWEEP (idx=2) -> immediate IDLE, busy=0, positions back to initial values.

Source files
------------

// File: rtl/bse_pkg.sv
// Shared types and arithmetic helpers for the bounce sprite engine.
package bse_pkg;

  localparam int BSE_POS_W = 9;
  localparam int BSE_VEL_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DONE
  } state_e;

  typedef logic signed [BSE_POS_W-1:0] pos_t;
  typedef logic signed [BSE_VEL_W-1:0] vel_t;

  typedef struct packed {
    pos_t x;
    pos_t y;
    vel_t vx;
    vel_t vy;
  } ball_t;

  // Mirror an overshoot past either wall back into 0..max_pos.
  function automatic pos_t reflect(input pos_t nx, input pos_t max_pos);
    if (nx[BSE_POS_W-1]) return -nx;
    if (nx > max_pos) return max_pos - (nx - max_pos);
    return nx;
  endfunction

  // Negation that maps the most negative velocity to the most positive one instead of itself.
  function automatic vel_t neg_sat(input vel_t v);
    vel_t most_neg;
    most_neg = {1'b1, {(BSE_VEL_W-1){1'b0}}};
    return (v == most_neg) ? ~most_neg : -v;
  endfunction

  function automatic pos_t init_pos(input int base, input int step, input int i, input int max_pos);
    return pos_t'((base + step * i) % (max_pos + 1));
  endfunction

endpackage

// File: rtl/bse_axis_step.sv
// One-axis motion step: add velocity, reflect off 0 / MAX_POS, negate velocity on a bounce.
module bse_axis_step
  import bse_pkg::*;
#(
  parameter int MAX_POS = 156
) (
  input  pos_t pos_i,
  input  vel_t vel_i,
  output pos_t pos_o,
  output vel_t vel_o
);

  localparam pos_t MAX = pos_t'(MAX_POS);

  pos_t nx;
  logic under;
  logic over;

  always_comb begin
    nx    = pos_i + pos_t'(vel_i);
    under = nx[BSE_POS_W-1];
    over  = !under && (nx > MAX);
    pos_o = reflect(nx, MAX);
    vel_o = (under || over) ? neg_sat(vel_i) : vel_i;
  end

endmodule

// File: rtl/bounce_sprite_engine.sv
// N-ball bounce engine: one ball updated per clock after each vsync rising edge; registered pixel hit/ID.
// Optional feature macro BSE_BALL_COLLIDE_EN adds ball_collide and neighbour bounce during the sweep.
module bounce_sprite_engine
  import bse_pkg::*;
#(
  parameter int  NUM_BALLS = 4,
  parameter int  H_RES     = 160,
  parameter int  V_RES     = 128,
  parameter int  BALL_SIZE = 4,
  parameter int  X0        = 60,
  parameter int  Y0        = 60,
  localparam int ID_W      = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            vsync,
  input  logic [7:0]      hpos,
  input  logic [7:0]      vpos,
  input  logic            run,
  output logic            pix_hit,
  output logic [ID_W-1:0] pix_id,
  output logic            busy,
  output logic            overrun,
  output logic [7:0]      frame_cnt
`ifdef BSE_BALL_COLLIDE_EN
  ,
  output logic            ball_collide
`endif
);

  localparam int                   X_MAX    = H_RES - BALL_SIZE;
  localparam int                   Y_MAX    = V_RES - BALL_SIZE;
  localparam logic [ID_W-1:0]      LAST_IDX = ID_W'(NUM_BALLS - 1);
  localparam logic [BSE_POS_W-1:0] SIZE_U   = BSE_POS_W'(BALL_SIZE);

  state_e          state_q, state_d;
  logic [ID_W-1:0] idx_q, idx_d;
  logic [7:0]      frame_q, frame_d;
  logic            overrun_q, overrun_d;
  logic            vs_q;
  logic            vs_rise;

  ball_t ball_q [NUM_BALLS];
  ball_t cur;
  ball_t ball_nxt;
  pos_t  nx, ny;
  vel_t  nvx, nvy;

  logic [NUM_BALLS-1:0] in_ball;
  logic                 pix_hit_q, pix_hit_d;
  logic [ID_W-1:0]      pix_id_q, pix_id_d;

  function automatic ball_t init_ball(input int i);
    ball_t b;
    b.x  = init_pos(X0, 8, i, X_MAX);
    b.y  = init_pos(Y0, 4, i, Y_MAX);
    b.vx = (i % 2 == 1) ? vel_t'(2) : vel_t'(-2);
    b.vy = vel_t'(2);
    return b;
  endfunction

  assign vs_rise = vsync & ~vs_q;

  // ---------------------------------------------------------------- control FSM
  always_comb begin
    // NOTE: every variable gets its hold value first, so no path can leave one unassigned and infer a latch.
    state_d   = state_q;
    idx_d     = idx_q;
    frame_d   = frame_q;
    overrun_d = overrun_q;
    case (state_q)
      IDLE: begin
        if (vs_rise) begin
          if (run) begin
            state_d = SWEEP;
            idx_d   = '0;
          end else begin
            frame_d = frame_q + 8'd1;
          end
        end
      end
      SWEEP: begin
        if (idx_q == LAST_IDX) state_d = DONE;
        else                   idx_d   = idx_q + 1'b1;
      end
      DONE: begin
        frame_d = frame_q + 8'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (vs_rise && state_q != IDLE) overrun_d = 1'b1;
  end

  // NOTE: sequential state is written only with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      frame_q   <= '0;
      overrun_q <= 1'b0;
      vs_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      frame_q   <= frame_d;
      overrun_q <= overrun_d;
      vs_q      <= vsync;
    end
  end

  assign busy      = (state_q != IDLE);
  assign overrun   = overrun_q;
  assign frame_cnt = frame_q;

  // ---------------------------------------------------------------- sweep datapath
  assign cur = ball_q[idx_q];

  bse_axis_step #(.MAX_POS(X_MAX)) u_step_x (
    .pos_i (cur.x),
    .vel_i (cur.vx),
    .pos_o (nx),
    .vel_o (nvx)
  );

  bse_axis_step #(.MAX_POS(Y_MAX)) u_step_y (
    .pos_i (cur.y),
    .vel_i (cur.vy),
    .pos_o (ny),
    .vel_o (nvy)
  );

`ifdef BSE_BALL_COLLIDE_EN
  ball_t prev;
  pos_t  dx, dy, adx, ady;
  logic  bump;

  // Ball idx-1 has already been updated this frame, so compare against its new position.
  assign prev = ball_q[idx_q - 1'b1];

  always_comb begin
    dx   = nx - prev.x;
    dy   = ny - prev.y;
    adx  = dx[BSE_POS_W-1] ? -dx : dx;
    ady  = dy[BSE_POS_W-1] ? -dy : dy;
    bump = (idx_q != '0) && (adx < pos_t'(BALL_SIZE)) && (ady < pos_t'(BALL_SIZE));
  end
`endif

  always_comb begin
    ball_nxt = '{x: nx, y: ny, vx: nvx, vy: nvy};
`ifdef BSE_BALL_COLLIDE_EN
    if (bump) ball_nxt.vx = neg_sat(nvx);
`endif
  end

  // NOTE: the ball array is plain flops rather than RAM, so it takes the async reset and reloads start positions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_BALLS; i++) ball_q[i] <= init_ball(i);
    end else if (state_q == SWEEP) begin
      ball_q[idx_q] <= ball_nxt;
`ifdef BSE_BALL_COLLIDE_EN
      if (bump) ball_q[idx_q - 1'b1].vx <= neg_sat(prev.vx);
`endif
    end
  end

  // ---------------------------------------------------------------- pixel path
  // Unsigned differences wrap pixels left of / above a ball to large values, so one compare per axis suffices.
  for (genvar g = 0; g < NUM_BALLS; g++) begin : g_hit
    logic [BSE_POS_W-1:0] dh;
    logic [BSE_POS_W-1:0] dv;
    assign dh         = BSE_POS_W'(hpos) - $unsigned(ball_q[g].x);
    assign dv         = BSE_POS_W'(vpos) - $unsigned(ball_q[g].y);
    assign in_ball[g] = (dh < SIZE_U) && (dv < SIZE_U);
  end

  always_comb begin
    pix_hit_d = |in_ball;
    pix_id_d  = '0;
    for (int i = NUM_BALLS - 1; i >= 0; i--) begin
      if (in_ball[i]) pix_id_d = ID_W'(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_hit_q <= 1'b0;
      pix_id_q  <= '0;
    end else begin
      pix_hit_q <= pix_hit_d;
      pix_id_q  <= pix_id_d;
    end
  end

  assign pix_hit = pix_hit_q;
  assign pix_id  = pix_id_q;

`ifdef BSE_BALL_COLLIDE_EN
  logic collide_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) collide_q <= 1'b0;
    else       collide_q <= (in_ball & (in_ball - 1'b1)) != '0;
  end

  assign ball_collide = collide_q;
`endif

endmodule

// File: tb/tb_bounce_sprite_engine.sv
// Self-checking bench for bounce_sprite_engine (default build): vector table, directed corner cases,
// and randomized frames compared against a frame-level behavioural model.
module tb_bounce_sprite_engine;

  localparam int NB   = 4;
  localparam int XMAX = 160 - 4;
  localparam int YMAX = 128 - 4;
  localparam int SZ   = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       vsync;
  logic       run;
  logic [7:0] hpos;
  logic [7:0] vpos;
  logic       pix_hit;
  logic [1:0] pix_id;
  logic       busy;
  logic       overrun;
  logic [7:0] frame_cnt;

  int errors = 0;
  int checks = 0;

  int mx [NB];
  int my [NB];
  int mvx[NB];
  int mvy[NB];
  int exp_frame;

  typedef struct {
    int h;
    int v;
    int hit;
    int id;
  } pix_vec_t;

  pix_vec_t tbl[11];

  always #5 clk = ~clk;

  bounce_sprite_engine dut (
    .clk       (clk),
    .reset     (reset),
    .vsync     (vsync),
    .hpos      (hpos),
    .vpos      (vpos),
    .run       (run),
    .pix_hit   (pix_hit),
    .pix_id    (pix_id),
    .busy      (busy),
    .overrun   (overrun),
    .frame_cnt (frame_cnt)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------- reference model
  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      mx[i]  = (60 + 8 * i) % (XMAX + 1);
      my[i]  = (60 + 4 * i) % (YMAX + 1);
      mvx[i] = (i % 2 == 1) ? 2 : -2;
      mvy[i] = 2;
    end
    exp_frame = 0;
  endtask

  function automatic int negv(input int v);
    return (v == -8) ? 7 : -v;
  endfunction

  task automatic move_axis(inout int p, inout int v, input int lim);
    int n;
    n = p + v;
    if (n < 0) begin
      p = -n;
      v = negv(v);
    end else if (n > lim) begin
      p = 2 * lim - n;
      v = negv(v);
    end else begin
      p = n;
    end
  endtask

  task automatic advance_all();
    for (int i = 0; i < NB; i++) begin
      move_axis(mx[i], mvx[i], XMAX);
      move_axis(my[i], mvy[i], YMAX);
    end
  endtask

  function automatic int exp_id(input int h, input int v);
    for (int i = 0; i < NB; i++)
      if (h >= mx[i] && h < mx[i] + SZ && v >= my[i] && v < my[i] + SZ) return i;
    return -1;
  endfunction

  // ---------------------------------------------------------------- stimulus helpers
  task automatic probe(input int h, input int v);
    int e;
    h = h & 255;
    v = v & 255;
    hpos = 8'(h);
    vpos = 8'(v);
    tick();
    e = exp_id(h, v);
    check("pix_hit", pix_hit, (e >= 0) ? 1 : 0);
    check("pix_id", pix_id, (e >= 0) ? e : 0);
  endtask

  task automatic probe_balls();
    for (int i = 0; i < NB; i++) begin
      probe(mx[i], my[i]);
      probe(mx[i] - 1, my[i] + 1);
      probe(mx[i] + SZ - 1, my[i] + SZ);
      probe(mx[i] + int'($urandom_range(0, 5)) - 1, my[i] + int'($urandom_range(0, 5)) - 1);
    end
  endtask

  task automatic do_frame(input bit run_v);
    int cnt;
    cnt   = 0;
    run   = run_v;
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    while (busy === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
    if (run_v) advance_all();
    exp_frame = (exp_frame + 1) % 256;
    check("busy_cycles", cnt, run_v ? NB + 1 : 0);
    check("frame_cnt", frame_cnt, exp_frame);
  endtask

  initial begin
    tbl[0]  = '{h: 60,  v: 60,  hit: 1, id: 0};
    tbl[1]  = '{h: 63,  v: 63,  hit: 1, id: 0};
    tbl[2]  = '{h: 64,  v: 60,  hit: 0, id: 0};
    tbl[3]  = '{h: 59,  v: 60,  hit: 0, id: 0};
    tbl[4]  = '{h: 84,  v: 72,  hit: 1, id: 3};
    tbl[5]  = '{h: 87,  v: 75,  hit: 1, id: 3};
    tbl[6]  = '{h: 88,  v: 72,  hit: 0, id: 0};
    tbl[7]  = '{h: 68,  v: 64,  hit: 1, id: 1};
    tbl[8]  = '{h: 76,  v: 71,  hit: 1, id: 2};
    tbl[9]  = '{h: 0,   v: 0,   hit: 0, id: 0};
    tbl[10] = '{h: 255, v: 255, hit: 0, id: 0};

    reset = 1'b1;
    vsync = 1'b0;
    run   = 1'b0;
    hpos  = 8'd0;
    vpos  = 8'd0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    model_reset();

    // Reset state
    check("rst_pix_hit", pix_hit, 0);
    check("rst_pix_id", pix_id, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_frame_cnt", frame_cnt, 0);

    // Pixel lookup against the start positions
    for (int i = 0; i < 11; i++) begin
      hpos = 8'(tbl[i].h);
      vpos = 8'(tbl[i].v);
      tick();
      check("tbl_hit", pix_hit, tbl[i].hit);
      check("tbl_id", pix_id, tbl[i].id);
    end

    // One frame: ball 0 moves from (60,60) to (58,62)
    do_frame(1'b1);
    hpos = 8'd58;
    vpos = 8'd62;
    tick();
    check("step_hit", pix_hit, 1);
    check("step_id", pix_id, 0);
    hpos = 8'd62;
    tick();
    check("step_miss_hit", pix_hit, 0);
    check("step_miss_id", pix_id, 0);

    // Second vsync edge two clocks after the first: overrun, single advance
    begin
      int cnt;
      check("pre_overrun", overrun, 0);
      run   = 1'b1;
      vsync = 1'b1;
      tick();
      vsync = 1'b0;
      tick();
      vsync = 1'b1;
      tick();
      vsync = 1'b0;
      cnt = 2;
      while (busy === 1'b1 && cnt < 40) begin
        cnt++;
        tick();
      end
      advance_all();
      exp_frame = (exp_frame + 1) % 256;
      check("ovr_busy_cycles", cnt, NB + 1);
      check("ovr_overrun", overrun, 1);
      check("ovr_frame_cnt", frame_cnt, exp_frame);
      probe_balls();
    end

    // run=0 counts the frame but freezes positions; overrun stays sticky
    do_frame(1'b0);
    probe_balls();
    check("ovr_sticky", overrun, 1);

    // Asynchronous reset in the middle of a sweep (idx=2)
    run   = 1'b1;
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_frame_cnt", frame_cnt, 0);
    check("midrst_overrun", overrun, 0);
    check("midrst_pix_hit", pix_hit, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    model_reset();
    probe_balls();

    // Randomized frames: long enough for every wall to be hit at least once
    for (int f = 0; f < 120; f++) begin
      do_frame($urandom_range(0, 7) != 0);
      check("rand_overrun", overrun, 0);
      probe_balls();
      for (int k = 0; k < 2; k++) probe(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
